// File: rtl/fib_write_checker.sv
// Snoops the data-memory write port and checks that a Fibonacci sequence is written, in order,
// to a fixed address window. Purely observational; reports pass/fail status and diagnostics.
module fib_write_checker #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned BASE_ADDR   = 128,
  parameter int unsigned N_TERMS     = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned IDX_W       = $clog2(N_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              clear,
  input  logic              seed_sel,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        err_code,
  output logic [IDX_W-1:0]  terms_ok,
  output logic [DATA_W-1:0] err_data,
  output logic              overflow
);

  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ADDR_W:0] ADDR_LO = (ADDR_W + 1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] ADDR_HI = (ADDR_W + 1)'(BASE_ADDR + N_TERMS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_t;

  state_t            state;
  logic [DATA_W-1:0] exp_a;
  logic [DATA_W-1:0] exp_b;
  logic [TO_W-1:0]   to_cnt;

  logic [ADDR_W:0]   addr_ext;
  logic              in_win;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W:0]   sum;

  always_comb begin
    addr_ext = {1'b0, mem_addr};
    in_win   = mem_we && (addr_ext >= ADDR_LO) && (addr_ext <= ADDR_HI);
    addr_ok  = (addr_ext == ADDR_LO + (ADDR_W + 1)'(terms_ok));
    data_ok  = (mem_wdata == exp_a);
    sum      = {1'b0, exp_a} + {1'b0, exp_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      busy     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      err_code <= 2'b00;
      terms_ok <= '0;
      err_data <= '0;
      overflow <= 1'b0;
      exp_a    <= '0;
      exp_b    <= '0;
      to_cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (arm) begin
            state    <= StRun;
            busy     <= 1'b1;
            exp_a    <= seed_sel ? DATA_W'(1) : '0;
            exp_b    <= DATA_W'(1);
            terms_ok <= '0;
            overflow <= 1'b0;
            err_code <= 2'b00;
            err_data <= '0;
            to_cnt   <= '0;
          end
        end
        StRun: begin
          if (in_win && !addr_ok) begin
            state    <= StFail;
            busy     <= 1'b0;
            fail     <= 1'b1;
            err_code <= 2'b10;
            err_data <= mem_wdata;
          end else if (in_win && !data_ok) begin
            state    <= StFail;
            busy     <= 1'b0;
            fail     <= 1'b1;
            err_code <= 2'b01;
            err_data <= mem_wdata;
          end else if (in_win) begin
            // Accepted write wins over a timeout landing in the same cycle.
            terms_ok <= terms_ok + IDX_W'(1);
            exp_a    <= exp_b;
            exp_b    <= sum[DATA_W-1:0];
            to_cnt   <= '0;
            if (sum[DATA_W]) overflow <= 1'b1;
            if (terms_ok == LAST_IDX) begin
              state <= StPass;
              busy  <= 1'b0;
              pass  <= 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            state    <= StFail;
            busy     <= 1'b0;
            fail     <= 1'b1;
            err_code <= 2'b11;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        StPass, StFail: begin
          // Diagnostics stay visible in IDLE until the next arm.
          if (clear) begin
            state <= StIdle;
            pass  <= 1'b0;
            fail  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_write_checker.sv
// Bench for fib_write_checker: table vectors, directed corner sequences and random traffic
// checked against a sequence-level reference model.
module tb_fib_write_checker;

  localparam int W  = 8;
  localparam int B  = 128;
  localparam int N  = 8;
  localparam int T  = 16;
  localparam int N2 = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm, clear, seed_sel, mem_we;
  logic [7:0] mem_addr, mem_wdata;

  logic       busy, pass, fail, overflow;
  logic [1:0] err_code;
  logic [3:0] terms_ok;
  logic [7:0] err_data;

  logic       busy2, pass2, fail2, overflow2;
  logic [1:0] err_code2;
  logic [3:0] terms_ok2;
  logic [7:0] err_data2;

  fib_write_checker #(
    .DATA_W(W), .ADDR_W(8), .BASE_ADDR(B), .N_TERMS(N), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .clear(clear), .seed_sel(seed_sel),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .pass(pass), .fail(fail), .err_code(err_code),
    .terms_ok(terms_ok), .err_data(err_data), .overflow(overflow)
  );

  fib_write_checker #(
    .DATA_W(W), .ADDR_W(8), .BASE_ADDR(B), .N_TERMS(N2), .TIMEOUT_CYC(64)
  ) dut2 (
    .clk(clk), .rst(rst), .arm(arm), .clear(clear), .seed_sel(seed_sel),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy2), .pass(pass2), .fail(fail2), .err_code(err_code2),
    .terms_ok(terms_ok2), .err_data(err_data2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string cur = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sequence terms are recomputed from the seed, not tracked incrementally.
  int m_state, m_seed, m_tok, m_err, m_ed, m_ovf, m_idle;

  function automatic int fib(input int seed, input int k);
    int a, b, t;
    a = seed;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = (a + b) % 256;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int carry(input int seed, input int k);
    return ((fib(seed, k) + fib(seed, k + 1)) > 255) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_seed = 0; m_tok = 0; m_err = 0; m_ed = 0; m_ovf = 0; m_idle = 0;
  endtask

  task automatic model_fail(input int code, input int ed);
    m_state = 3;
    m_err   = code;
    m_ed    = ed;
  endtask

  task automatic model_edge();
    int inwin;
    case (m_state)
      0: if (arm) begin
        m_state = 1; m_seed = int'(seed_sel);
        m_tok = 0; m_err = 0; m_ed = 0; m_ovf = 0; m_idle = 0;
      end
      1: begin
        inwin = (mem_we && int'(mem_addr) >= B && int'(mem_addr) < B + N) ? 1 : 0;
        if (inwin != 0 && int'(mem_addr) != B + m_tok) model_fail(2, int'(mem_wdata));
        else if (inwin != 0 && int'(mem_wdata) != fib(m_seed, m_tok))
          model_fail(1, int'(mem_wdata));
        else if (inwin != 0) begin
          if (carry(m_seed, m_tok) != 0) m_ovf = 1;
          m_tok++;
          m_idle = 0;
          if (m_tok == N) m_state = 2;
        end else begin
          m_idle++;
          if (m_idle == T) model_fail(3, m_ed);
        end
      end
      default: if (clear) m_state = 0;
    endcase
  endtask

  task automatic compare_model();
    logic [17:0] act, exp;
    act = {busy, pass, fail, err_code, terms_ok, err_data, overflow};
    exp = {1'(m_state == 1), 1'(m_state == 2), 1'(m_state == 3), 2'(m_err), 4'(m_tok),
           8'(m_ed), 1'(m_ovf)};
    check({"model/", cur}, 32'(act), 32'(exp));
  endtask

  task automatic step(input logic a, input logic c, input logic s, input logic we,
                      input logic [7:0] ad, input logic [7:0] d);
    @(negedge clk);
    arm = a; clear = c; seed_sel = s; mem_we = we; mem_addr = ad; mem_wdata = d;
    @(posedge clk);
    model_edge();
    #1 compare_model();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic wr(input int ad, input int d);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'(ad), 8'(d));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    arm = 0; clear = 0; seed_sel = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic a, c, s, we;
    logic [7:0] ad, d;
    logic busy, pass, fail;
    logic [1:0] err;
    logic [3:0] tok;
    logic [7:0] ed;
  } vec_t;

  function automatic vec_t mk(input int a, c, s, we, ad, d, bz, ps, fl, er, tk, ed);
    vec_t v;
    v.a = 1'(a); v.c = 1'(c); v.s = 1'(s); v.we = 1'(we); v.ad = 8'(ad); v.d = 8'(d);
    v.busy = 1'(bz); v.pass = 1'(ps); v.fail = 1'(fl); v.err = 2'(er); v.tok = 4'(tk);
    v.ed = 8'(ed);
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] ex;

    tbl[0]  = mk(1, 0, 0, 0, 0,   0,  1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 128, 0,  1, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 129, 1,  1, 0, 0, 0, 2, 0);
    tbl[3]  = mk(0, 0, 0, 1, 130, 2,  0, 0, 1, 1, 2, 2);
    tbl[4]  = mk(1, 0, 0, 0, 0,   0,  0, 0, 1, 1, 2, 2);
    tbl[5]  = mk(0, 1, 0, 0, 0,   0,  0, 0, 0, 1, 2, 2);
    tbl[6]  = mk(1, 0, 1, 0, 0,   0,  1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 1, 128, 1,  1, 0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 1, 10,  99, 1, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 1, 130, 1,  0, 0, 1, 2, 1, 1);
    tbl[10] = mk(0, 1, 0, 0, 0,   0,  0, 0, 0, 2, 1, 1);
    tbl[11] = mk(0, 1, 0, 1, 128, 0,  0, 0, 0, 2, 1, 1);
    tbl[12] = mk(1, 0, 0, 0, 0,   0,  1, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 128, 5,  0, 0, 1, 1, 0, 5);
    tbl[14] = mk(0, 0, 0, 1, 136, 0,  0, 0, 1, 1, 0, 5);

    rst = 1'b0;
    arm = 0; clear = 0; seed_sel = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    model_reset();
    #12;
    check("reset_outputs", 32'({busy, pass, fail, err_code, terms_ok, err_data, overflow}), 0);
    do_reset();

    cur = "table";
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].a, tbl[i].c, tbl[i].s, tbl[i].we, tbl[i].ad, tbl[i].d);
      check($sformatf("tbl[%0d]", i), 32'({busy, pass, fail, err_code, terms_ok, err_data}),
            32'({tbl[i].busy, tbl[i].pass, tbl[i].fail, tbl[i].err, tbl[i].tok, tbl[i].ed}));
    end

    // Full pass with gaps and stray writes, then arm+clear together from PASS.
    cur = "pass_seq";
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        if ($urandom_range(0, 1) == 1) wr(10, int'($urandom_range(0, 255)));
        else idle_n(1);
      end
      wr(B + k, fib(0, k));
    end
    check("pass_flags", 32'({pass, fail, busy}), 32'(3'b100));
    check("pass_terms", 32'(terms_ok), 8);
    check("pass_err", 32'({err_code, overflow}), 0);
    cur = "arm_clear";
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    check("arm_clear_idle", 32'({busy, pass, fail, terms_ok}), 32'({3'b000, 4'd8}));
    idle_n(1);
    check("arm_clear_stays_idle", 32'(busy), 0);

    // Timeout with no writes: fail exactly TIMEOUT_CYC cycles after arm.
    cur = "timeout";
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    idle_n(T - 1);
    check("timeout_not_yet", 32'({busy, fail}), 32'(2'b10));
    idle_n(1);
    check("timeout_fail", 32'({busy, fail, err_code}), 32'({2'b01, 2'b11}));

    // Accepted write on the would-be timeout cycle keeps RUN going.
    cur = "timeout_accept";
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    wr(B, 0);
    idle_n(T - 1);
    wr(B + 1, 1);
    check("timeout_accept_run", 32'({busy, fail, terms_ok}), 32'({2'b10, 4'd2}));
    idle_n(T - 1);
    check("timeout_accept_still", 32'(busy), 1);
    idle_n(1);
    check("timeout_accept_fail", 32'({fail, err_code, terms_ok}), 32'({1'b1, 2'b11, 4'd2}));

    // Overflow on the 15-term instance: carry first appears at 144+233.
    cur = "overflow";
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int k = 0; k < N2; k++) begin
      wr(B + k, fib(0, k));
      if (k == 11) check("ovf_before", 32'(overflow2), 0);
      if (k == 12) check("ovf_after", 32'(overflow2), 1);
    end
    check("ovf_term14", fib(0, 14), 121);
    check("ovf_pass", 32'({pass2, fail2, err_code2, terms_ok2, overflow2}),
          32'({2'b10, 2'b00, 4'd15, 1'b1}));

    // Asynchronous reset mid-RUN.
    cur = "async_reset";
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    wr(B, 0); wr(B + 1, 1); wr(B + 2, 1);
    check("pre_reset_terms", 32'(terms_ok), 3);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("async_reset_outputs",
             32'({busy, pass, fail, err_code, terms_ok, err_data, overflow}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model.
    cur = "random";
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r = int'($urandom_range(0, 99));
      ex = 8'(fib(m_seed, m_tok));
      if (m_state == 0) begin
        if (r < 30) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'd0, 8'd0);
        else step(1'b0, 1'(r < 40), 1'b0, 1'(r < 60), 8'($urandom), 8'($urandom));
      end else if (m_state == 1) begin
        if (r < 55) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(B + m_tok), ex);
        else if (r < 70) step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom_range(0, B - 1)),
                              8'($urandom));
        else if (r < 73)
          step(1'b0, 1'b0, 1'b0, 1'b1,
               8'(B + (m_tok + 1 + int'($urandom_range(0, N - 2))) % N), 8'($urandom));
        else if (r < 76)
          step(1'b0, 1'b0, 1'b0, 1'b1, 8'(B + m_tok), ex ^ 8'($urandom_range(1, 255)));
        else if (r < 78) idle_n(T + 1);
        else step(1'(r < 85), 1'(r >= 95), 1'b0, 1'b0, 8'd0, 8'd0);
      end else begin
        if (r < 40) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        else step(1'(r < 60), 1'b0, 1'b0, 1'b1, 8'(B), 8'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fib_write_checker.md
# fib_write_checker

Synthesisable, parametrised monitor that snoops the MiniMIPS data-memory write port and checks that the program writes a Fibonacci sequence to a fixed address window, in order. It replaces simulation-only inspection of the Fibonacci program with on-chip pass/fail status that can drive board LEDs. It sits beside the `mips` core on the memory write bus, is purely observational, and never stalls the core.

## Interface
- `DATA_W`, default 8: data-bus and sequence-term width.
- `ADDR_W`, default 8: memory address width.
- `BASE_ADDR`, default 128: address of term 0; term k is expected at `BASE_ADDR+k`.
- `N_TERMS`, default 8: number of terms for a pass; range 2..255.
- `TIMEOUT_CYC`, default 1024: maximum idle cycles between accepted writes while running.
- `IDX_W`, derived as clog2(`N_TERMS`+1): counter width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `arm` in 1: start checking; single-cycle pulse.
- `clear` in 1: return from PASS/FAIL to IDLE.
- `seed_sel` in 1: 0 selects seeds (0,1); 1 selects seeds (1,1).
- `mem_we` in 1: memory write strobe from the core.
- `mem_addr` in ADDR_W: write address.
- `mem_wdata` in DATA_W: write data.
- `busy` out 1: high in RUN.
- `pass` out 1: high in PASS.
- `fail` out 1: high in FAIL.
- `err_code` out 2: 00 none, 01 data mismatch, 10 order error, 11 timeout.
- `terms_ok` out IDX_W: count of correctly checked terms.
- `err_data` out DATA_W: offending `mem_wdata` on a data or order error, else 0.
- `overflow` out 1: sticky; set when an expected-term addition carries out of DATA_W.

## Operation
- States: IDLE, RUN, PASS, FAIL. All outputs are registered and decoded from state and registers.
- IDLE: `arm`=1 moves to RUN. On that edge, latch the seeds into `exp_a`/`exp_b`, and zero `terms_ok`, `overflow`, `err_code`, `err_data`, and the timeout counter.
- RUN write handling: a write is in-window when `mem_we`=1 and `BASE_ADDR` <= `mem_addr` <= `BASE_ADDR+N_TERMS-1`. Out-of-window writes are ignored.
  - In-window write with `mem_addr` != `BASE_ADDR+terms_ok`: go to FAIL with `err_code`=10 and latch `err_data`.
  - Correct address with `mem_wdata` != `exp_a`: go to FAIL with `err_code`=01 and latch `err_data`.
  - Otherwise the write is accepted: `terms_ok`++, `exp_a`<=`exp_b`, `exp_b`<=(`exp_a`+`exp_b`) mod 2^DATA_W, and `overflow` is set on carry-out. If the new `terms_ok` equals `N_TERMS`, go to PASS.
- RUN timeout: the counter increments on every non-accepted cycle and clears on each accepted write. When it reaches `TIMEOUT_CYC`-1 with no accepted write that cycle, go to FAIL with `err_code`=11.
- PASS/FAIL: hold all outputs. `clear`=1 returns to IDLE, and outputs keep their values until the next `arm`.
- Priorities:
  - `clear` beats `arm` in the same cycle.
  - `arm` is ignored in RUN, PASS and FAIL.
  - `clear` is ignored in IDLE and RUN.
  - An accepted write beats a timeout in the same cycle.
- `overflow` is informational only and never causes FAIL.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `busy`/`pass`/`fail`/`overflow`=0; `err_code`=00; `terms_ok`=0; `err_data`=0; expected registers and timeout counter 0.
- Reset asserted mid-RUN aborts immediately to IDLE with no FAIL indication.
- `busy` rises the cycle after the `arm` edge.
- A write sampled at edge n updates `terms_ok` and `exp_*` at edge n. `pass`/`fail` are visible after edge n, i.e. one-cycle latency.
- Back-to-back writes on consecutive cycles are fully supported.

## Test plan
- Seeds (0,1), N_TERMS=8: arm, then write 0,1,1,2,3,5,8,13 to addresses 128..135, with gaps of 0–3 cycles and stray writes to address 10 interleaved -> `pass`=1, `terms_ok`=8, `err_code`=00, `overflow`=0.
- Seeds (0,1): write 0 and 1, then write 2 to address 130 -> `fail`=1, `err_code`=01, `err_data`=2, `terms_ok`=2.
- Seeds (1,1): write 1 to address 128, then write 1 to address 130 -> `fail`=1, `err_code`=10, `err_data`=1, `terms_ok`=1.
- TIMEOUT_CYC=16: arm with no writes -> `fail` after 16 cycles, `err_code`=11. Also: a correct write landing on the would-be timeout cycle is accepted and RUN continues.
- N_TERMS=15, DATA_W=8, seeds (0,1): terms through 233, then write 121 as term 14 (377 mod 256) -> `pass`=1, `overflow`=1.
- Assert `rst` low after 3 accepted writes -> all outputs return to reset values asynchronously. Then: `arm`+`clear` in the same cycle from PASS -> IDLE, not RUN.
